// File: rtl/apu_chunk_dma.sv
// apu_chunk_dma: upstream DDR3 reader for the APU sample path.
// Each queued 512-byte sample buffer is read as 64 consecutive 64-bit words
// into a small chunk FIFO. The FIFO head is offered to the chunk player as
// an 8-sample chunk. A base that is queued by the time the last word returns
// is chained with no idle cycle, so playback runs gap-free across buffers.
module apu_chunk_dma #(
   parameter int FIFO_DEPTH = 4,   // chunk FIFO entries, power of two, >= 2
   parameter int BUF_WORDS  = 64   // words per buffer, fixed by 512-byte alignment
) (
   input  logic        clock,
   input  logic        reset,
   input  logic [22:0] base,
   input  logic        base_valid,
   output logic        base_ack,
   input  logic        flush,
   input  logic [63:0] mem_data,
   input  logic        mem_ack,
   output logic [28:0] mem_addr,
   output logic        mem_read_en,
   output logic [63:0] chunk,
   output logic        chunk_valid,
   input  logic        chunk_ack,
   output logic        busy
);

   localparam int         PTR_W    = $clog2(FIFO_DEPTH);
   localparam int         CNT_W    = PTR_W + 1;
   localparam logic [5:0] LAST_IDX = 6'(BUF_WORDS - 1);

   // IDLE : no buffer in progress
   // READ : read request outstanding (mem_read_en=1)
   // STALL: buffer in progress, waiting for a free FIFO slot
   // DRAIN: flushed while a read was outstanding; its data is discarded
   typedef enum logic [1:0] {IDLE, READ, STALL, DRAIN} state_t;

   state_t           state;
   logic [22:0]      cur_base;
   logic [5:0]       word_idx;

   logic [63:0]      fifo_mem [FIFO_DEPTH];
   logic [PTR_W-1:0] rd_ptr;
   logic [PTR_W-1:0] wr_ptr;
   logic [CNT_W-1:0] fifo_count;
   logic [CNT_W-1:0] count_next;

   logic             push;
   logic             pop;
   logic             last_word;
   logic             take_idle;
   logic             take_chain;
   logic             room;

   // A returned word is kept unless the same cycle flushes the buffer.
   assign push       = (state == READ) && mem_ack && !flush;
   assign pop        = chunk_ack && chunk_valid;
   assign last_word  = (word_idx == LAST_IDX);

   // A base is taken either from IDLE or, for chaining, on the last word's return.
   assign take_idle  = (state == IDLE) && base_valid && !flush;
   assign take_chain = push && last_word && base_valid;
   assign base_ack   = !reset && (take_idle || take_chain);

   // Occupancy after this cycle's push and pop; a new read is only issued
   // when this leaves a slot free, so the push on its mem_ack always fits.
   assign count_next = fifo_count + CNT_W'(push) - CNT_W'(pop);
   assign room       = (count_next < CNT_W'(FIFO_DEPTH));

   assign mem_addr    = {cur_base, word_idx};
   assign chunk_valid = (fifo_count != '0);
   // NOTE: the storage array has no reset; gating the head with chunk_valid gives
   // a clean zero on chunk after reset without resetting every entry.
   assign chunk       = chunk_valid ? fifo_mem[rd_ptr] : '0;

   // Buffer sequencing FSM; mem_read_en and busy are registered with the state.
   always_ff @(posedge clock) begin
      // NOTE: all state here is sequential, so every assignment is non-blocking;
      // blocking assignments would let later statements see next-cycle values.
      if (reset) begin
         state       <= IDLE;
         cur_base    <= '0;
         word_idx    <= '0;
         mem_read_en <= 1'b0;
         busy        <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (flush) begin
                  word_idx <= '0;
               end else if (take_idle) begin
                  cur_base    <= base;
                  word_idx    <= '0;
                  state       <= room ? READ : STALL;
                  mem_read_en <= room;
                  busy        <= 1'b1;
               end
            end

            READ: begin
               if (flush) begin
                  word_idx <= '0;
                  if (mem_ack) begin
                     state       <= IDLE;
                     mem_read_en <= 1'b0;
                     busy        <= 1'b0;
                  end else begin
                     // The read stays on the bus until DDR3 answers it.
                     state <= DRAIN;
                  end
               end else if (mem_ack) begin
                  if (!last_word) begin
                     word_idx    <= word_idx + 6'd1;
                     state       <= room ? READ : STALL;
                     mem_read_en <= room;
                  end else if (base_valid) begin
                     cur_base    <= base;
                     word_idx    <= '0;
                     state       <= room ? READ : STALL;
                     mem_read_en <= room;
                  end else begin
                     state       <= IDLE;
                     mem_read_en <= 1'b0;
                     busy        <= 1'b0;
                  end
               end
            end

            STALL: begin
               if (flush) begin
                  word_idx <= '0;
                  state    <= IDLE;
                  busy     <= 1'b0;
               end else if (room) begin
                  state       <= READ;
                  mem_read_en <= 1'b1;
               end
            end

            DRAIN: begin
               if (mem_ack) begin
                  state       <= IDLE;
                  mem_read_en <= 1'b0;
                  busy        <= 1'b0;
               end
            end

            default: begin
               state       <= IDLE;
               mem_read_en <= 1'b0;
               busy        <= 1'b0;
            end
         endcase
      end
   end

   // FIFO pointers and occupancy; flush empties the FIFO in one cycle.
   always_ff @(posedge clock) begin
      if (reset || flush) begin
         rd_ptr     <= '0;
         wr_ptr     <= '0;
         fifo_count <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PTR_W'(1);
         if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
         fifo_count <= count_next;
      end
   end

   // FIFO storage write.
   always_ff @(posedge clock) begin
      if (push) fifo_mem[wr_ptr] <= mem_data;
   end

endmodule

// File: tb/tb_apu_chunk_dma.sv
// tb_apu_chunk_dma: randomized bench for apu_chunk_dma.
// A transaction-level reference model (buffer in progress, draining, current
// base and word, queue of words owed to the player) predicts every output
// each cycle. Directed phases cover single buffer, chaining, back-pressure,
// push/pop at FIFO_DEPTH-1, flush during a read and reset mid-buffer.
module tb_apu_chunk_dma;

   localparam int FIFO_DEPTH = 4;

   logic        clock = 1'b0;
   logic        reset;
   logic [22:0] base;
   logic        base_valid;
   logic        base_ack;
   logic        flush;
   logic [63:0] mem_data;
   logic        mem_ack;
   logic [28:0] mem_addr;
   logic        mem_read_en;
   logic [63:0] chunk;
   logic        chunk_valid;
   logic        chunk_ack;
   logic        busy;

   apu_chunk_dma #(.FIFO_DEPTH(FIFO_DEPTH), .BUF_WORDS(64)) dut (
      .clock       (clock),
      .reset       (reset),
      .base        (base),
      .base_valid  (base_valid),
      .base_ack    (base_ack),
      .flush       (flush),
      .mem_data    (mem_data),
      .mem_ack     (mem_ack),
      .mem_addr    (mem_addr),
      .mem_read_en (mem_read_en),
      .chunk       (chunk),
      .chunk_valid (chunk_valid),
      .chunk_ack   (chunk_ack),
      .busy        (busy)
   );

   always #5 clock = ~clock;

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", tag, got, exp);
      end
   endtask

   // DDR3 content: a distinct word for every word address.
   function automatic logic [63:0] data_for(input logic [28:0] a);
      return {a, 3'b101, ~a, 3'b010};
   endfunction

   // Stimulus policy.
   int          ack_pct;
   int          lat_min;
   int          lat_max;
   int          flush_pm;
   int          bv_pct;
   bit          force_flush;
   bit          force_ack;
   int          wait_cnt;
   logic [22:0] pend_q[$];

   // Observations.
   int          n_reads;
   int          n_pops;
   bit          chain_seen;
   logic [28:0] addr_log[$];

   // Reference model.
   bit          m_busy;
   bit          m_drain;
   bit          m_mre;
   logic [22:0] m_base;
   logic [5:0]  m_idx;
   logic [63:0] exp_q[$];

   function automatic void model_clear();
      m_busy  = 1'b0;
      m_drain = 1'b0;
      m_mre   = 1'b0;
      m_base  = '0;
      m_idx   = '0;
      exp_q.delete();
   endfunction

   // One clock cycle: called at a negedge, returns at the next negedge.
   task automatic do_cycle();
      logic exp_back;
      // DDR3 responder
      if (force_ack) begin
         mem_ack   = 1'b1;
         mem_data  = data_for(mem_addr);
         force_ack = 1'b0;
      end else if (mem_read_en) begin
         if (wait_cnt == 0) begin
            mem_ack  = 1'b1;
            mem_data = data_for(mem_addr);
            wait_cnt = $urandom_range(lat_max, lat_min);
         end else begin
            mem_ack  = 1'b0;
            mem_data = {$urandom, $urandom};
            wait_cnt--;
         end
      end else begin
         mem_ack  = 1'b0;
         mem_data = {$urandom, $urandom};
         wait_cnt = $urandom_range(lat_max, lat_min);
      end
      // player, flush source and base requester
      chunk_ack   = ($urandom_range(99, 0) < ack_pct);
      flush       = force_flush || ($urandom_range(999, 0) < flush_pm);
      force_flush = 1'b0;
      if (pend_q.size() > 0) begin
         base       = pend_q[0];
         base_valid = ($urandom_range(99, 0) < bv_pct);
      end else begin
         base       = 23'($urandom);
         base_valid = 1'b0;
      end
      #1;
      // outputs against the model's current view
      check("mem_read_en", 64'(mem_read_en), 64'(m_mre));
      check("busy", 64'(busy), 64'(m_busy));
      check("chunk_valid", 64'(chunk_valid), 64'(exp_q.size() != 0));
      if (exp_q.size() != 0) check("chunk", chunk, exp_q[0]);
      if (m_mre && !m_drain) check("mem_addr", 64'(mem_addr), 64'({m_base, m_idx}));
      // model step
      exp_back = 1'b0;
      if (reset) begin
         model_clear();
      end else if (flush) begin
         exp_q.delete();
         if (m_busy && !m_drain && m_mre) begin
            if (mem_ack) m_busy = 1'b0;
            else         m_drain = 1'b1;
         end else if (m_busy && m_drain) begin
            if (mem_ack) begin
               m_busy  = 1'b0;
               m_drain = 1'b0;
            end
         end else begin
            m_busy = 1'b0;
         end
         m_idx = '0;
      end else begin
         if (chunk_ack && exp_q.size() != 0) void'(exp_q.pop_front());
         if (!m_busy) begin
            if (base_valid) begin
               exp_back = 1'b1;
               m_base   = base;
               m_idx    = '0;
               m_busy   = 1'b1;
            end
         end else if (m_drain) begin
            if (mem_ack) begin
               m_busy  = 1'b0;
               m_drain = 1'b0;
            end
         end else if (m_mre && mem_ack) begin
            exp_q.push_back(data_for({m_base, m_idx}));
            if (m_idx != 6'd63) begin
               m_idx++;
            end else if (base_valid) begin
               exp_back = 1'b1;
               m_base   = base;
               m_idx    = '0;
            end else begin
               m_busy = 1'b0;
            end
         end
      end
      m_mre = m_busy && (m_drain || exp_q.size() < FIFO_DEPTH);
      check("base_ack", 64'(base_ack), 64'(exp_back));
      // observations and requester bookkeeping
      if (!reset && mem_ack && mem_read_en) begin
         n_reads++;
         addr_log.push_back(mem_addr);
         if (base_ack) chain_seen = 1'b1;
      end
      if (chunk_ack && chunk_valid) n_pops++;
      if (base_ack && pend_q.size() > 0) void'(pend_q.pop_front());
      @(negedge clock);
   endtask

   task automatic run_until_idle(input string tag, input int budget);
      int n = 0;
      while ((m_busy || exp_q.size() != 0 || pend_q.size() != 0) && n < budget) begin
         do_cycle();
         n++;
      end
      check({tag, "_timeout"}, 64'(n >= budget), 64'd0);
      check({tag, "_idle_busy"}, 64'(busy), 64'd0);
   endtask

   initial begin
      int n;
      int snap;
      reset      = 1'b1;
      base       = '0;
      base_valid = 1'b0;
      flush      = 1'b0;
      mem_data   = '0;
      mem_ack    = 1'b0;
      chunk_ack  = 1'b0;
      ack_pct    = 100;
      lat_min    = 2;
      lat_max    = 2;
      flush_pm   = 0;
      bv_pct     = 100;
      force_flush = 1'b0;
      force_ack  = 1'b0;
      wait_cnt   = 0;
      n_reads    = 0;
      n_pops     = 0;
      chain_seen = 1'b0;
      model_clear();

      // reset state
      repeat (3) @(negedge clock);
      check("rst_base_ack", 64'(base_ack), 64'd0);
      check("rst_mem_read_en", 64'(mem_read_en), 64'd0);
      check("rst_busy", 64'(busy), 64'd0);
      check("rst_chunk_valid", 64'(chunk_valid), 64'd0);
      check("rst_chunk", chunk, 64'd0);
      check("rst_mem_addr", 64'(mem_addr), 64'd0);
      reset = 1'b0;

      // single buffer, mem_ack two cycles after each request
      pend_q.push_back(23'h000010);
      n_reads = 0;
      n_pops  = 0;
      addr_log.delete();
      run_until_idle("single", 800);
      check("single_reads", 64'(n_reads), 64'd64);
      check("single_pops", 64'(n_pops), 64'd64);
      for (int i = 0; i < 64 && i < addr_log.size(); i++)
         check("single_addr", 64'(addr_log[i]), 64'(29'h400 + 29'(i)));

      // chaining into 23'h000020 on the last word
      pend_q.push_back(23'h000010);
      pend_q.push_back(23'h000020);
      chain_seen = 1'b0;
      n = 0;
      while (!chain_seen && n < 800) begin
         do_cycle();
         n++;
      end
      check("chain_seen", 64'(chain_seen), 64'd1);
      check("chain_addr", 64'(mem_addr), 64'h800);
      check("chain_busy", 64'(busy), 64'd1);
      check("chain_rd_en", 64'(mem_read_en), 64'd1);
      run_until_idle("chain", 800);

      // back-pressure: no chunk_ack at all
      ack_pct = 0;
      lat_min = 1;
      lat_max = 1;
      pend_q.push_back(23'($urandom));
      n_reads = 0;
      repeat (40) do_cycle();
      check("bp_reads", 64'(n_reads), 64'(FIFO_DEPTH));
      check("bp_rd_en", 64'(mem_read_en), 64'd0);
      check("bp_busy", 64'(busy), 64'd1);
      ack_pct = 100;
      do_cycle();
      ack_pct = 0;
      repeat (20) do_cycle();
      check("bp_one_more", 64'(n_reads), 64'(FIFO_DEPTH + 1));
      check("bp_rd_en2", 64'(mem_read_en), 64'd0);
      force_flush = 1'b1;
      do_cycle();
      ack_pct = 100;
      run_until_idle("bp", 100);

      // simultaneous push and pop at FIFO_DEPTH-1
      ack_pct = 0;
      lat_min = 0;
      lat_max = 0;
      pend_q.push_back(23'($urandom));
      n = 0;
      while (exp_q.size() != FIFO_DEPTH - 1 && n < 50) begin
         do_cycle();
         n++;
      end
      check("pp_fill_timeout", 64'(n >= 50), 64'd0);
      ack_pct = 100;
      repeat (12) begin
         do_cycle();
         check("pp_rd_en", 64'(mem_read_en), 64'd1);
         check("pp_valid", 64'(chunk_valid), 64'd1);
      end
      ack_pct = 0;
      snap = n_reads;
      repeat (10) do_cycle();
      check("pp_count_kept", 64'(n_reads - snap), 64'd1);
      ack_pct = 100;
      run_until_idle("pp", 400);

      // flush during an outstanding read, with a base pending
      ack_pct = 0;
      lat_min = 3;
      lat_max = 3;
      pend_q.push_back(23'($urandom));
      pend_q.push_back(23'($urandom));
      n = 0;
      while (!(exp_q.size() >= 2 && mem_read_en && wait_cnt > 0) && n < 100) begin
         do_cycle();
         n++;
      end
      check("fl_setup_timeout", 64'(n >= 100), 64'd0);
      force_flush = 1'b1;
      do_cycle();
      check("fl_drain_rd_en", 64'(mem_read_en), 64'd1);
      check("fl_drain_busy", 64'(busy), 64'd1);
      check("fl_valid", 64'(chunk_valid), 64'd0);
      check("fl_pending", 64'(pend_q.size()), 64'd1);
      ack_pct = 100;
      n_reads = 0;
      run_until_idle("flush", 800);
      check("fl_reads", 64'(n_reads), 64'd65);

      // reset at word 30 of a buffer, then a late mem_ack
      lat_min = 1;
      lat_max = 1;
      pend_q.push_back(23'($urandom));
      n = 0;
      while (!(m_idx == 6'd30 && mem_read_en) && n < 300) begin
         do_cycle();
         n++;
      end
      check("rs_setup_timeout", 64'(n >= 300), 64'd0);
      reset = 1'b1;
      do_cycle();
      reset = 1'b0;
      pend_q.delete();
      base_valid = 1'b0;
      #1;
      check("rs_rd_en", 64'(mem_read_en), 64'd0);
      check("rs_busy", 64'(busy), 64'd0);
      check("rs_valid", 64'(chunk_valid), 64'd0);
      check("rs_chunk", chunk, 64'd0);
      check("rs_addr", 64'(mem_addr), 64'd0);
      check("rs_base_ack", 64'(base_ack), 64'd0);
      force_ack = 1'b1;
      do_cycle();
      check("rs_late_ack", 64'(chunk_valid), 64'd0);

      // randomized traffic with occasional flushes
      ack_pct  = 60;
      lat_min  = 0;
      lat_max  = 3;
      flush_pm = 4;
      bv_pct   = 70;
      for (int i = 0; i < 8; i++) pend_q.push_back(23'($urandom));
      run_until_idle("random", 10000);
      flush_pm = 0;

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
